// File: rtl/time_sync_multi.sv
// time_sync_multi
//   Master time-keeper for the system clock domain. Holds a TIME_W-bit
//   master time that either free-runs (+1 per cycle) or is loaded from a
//   staged value, immediately or on a selected PPS edge. After every
//   PPS-triggered load the staged value advances by one second so the
//   following PPS loads the next second. Also provides NUM_TICK periodic
//   tick channels, a PPS-loss watchdog and a coherent snapshot readback.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   set_stb/addr/data   settings bus write port
//   rb_stb, rb_addr     readback request and select
//   rb_data             registered readback data
//   pps_in              raw PPS pin, asynchronous to clk
//   time_o              master time
//   pps_o               one-cycle pulse per detected PPS edge
//   tick_o              per-channel one-cycle tick pulses
//   int_o               registered tick interrupt
//   epoch_o             registered flag, high while time_o[27:0] == 0
//   pps_missing_o       sticky PPS-loss flag
module time_sync_multi #(
  parameter int TIME_W        = 64,
  parameter int NUM_TICK      = 2,
  parameter int BASE          = 0,
  parameter int TICKS_PER_SEC = 100000000,
  parameter int DEF_INTERVAL  = 99999
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_stb,
  input  logic [7:0]          set_addr,
  input  logic [31:0]         set_data,
  input  logic                rb_stb,
  input  logic [2:0]          rb_addr,
  output logic [31:0]         rb_data,
  input  logic                pps_in,
  output logic [TIME_W-1:0]   time_o,
  output logic                pps_o,
  output logic [NUM_TICK-1:0] tick_o,
  output logic                int_o,
  output logic                epoch_o,
  output logic                pps_missing_o
);

  localparam int HI_W = TIME_W - 32;

  localparam logic [7:0] A_CTRL = 8'(BASE);
  localparam logic [7:0] A_HI   = 8'(BASE + 1);
  localparam logic [7:0] A_LO   = 8'(BASE + 2);
  localparam logic [7:0] A_CMD  = 8'(BASE + 3);
  localparam logic [7:0] A_TMO  = 8'(BASE + 4);
  localparam logic [7:0] A_INT0 = 8'(BASE + 8);

  localparam logic [TIME_W-1:0] TPS_INC      = TIME_W'(TICKS_PER_SEC);
  localparam logic [31:0]       TIMEOUT_RST  = 32'(TICKS_PER_SEC + TICKS_PER_SEC / 8);
  localparam logic [31:0]       INTERVAL_RST = 32'(DEF_INTERVAL);

  // Settings and control state
  logic              ctrl_rising;
  logic              sync_every;
  logic              int_en;
  logic              watch_en;
  logic              armed;
  logic [31:0]       pps_timeout;
  logic [TIME_W-1:0] staged;
  logic [TIME_W-1:0] pps_time;
  logic [TIME_W-1:0] snapshot;

  // PPS synchroniser and edge flop
  logic pps_s1, pps_s2, pps_d;
  logic pps_ext;

  // Decoded bus writes
  logic                wr_ctrl, wr_hi, wr_lo, wr_cmd, wr_tmo;
  logic [NUM_TICK-1:0] wr_int;
  logic                load_now, arm_req, pps_load;

  // Next-state values
  logic [TIME_W-1:0] time_next;
  logic [TIME_W-1:0] staged_sum;
  logic [31:0]       staged_lo_next;
  logic [HI_W-1:0]   staged_hi_next;

  // Tick channels
  logic [31:0]         interval [NUM_TICK];
  logic [31:0]         tick_cnt [NUM_TICK];
  logic [NUM_TICK-1:0] tick;

  // Watchdog
  logic [31:0] since_pps;

  // Address decode of the settings bus. The cmd register splits into an
  // immediate load (data[0]=1) and an arm-for-next-PPS request (data[0]=0).
  always_comb begin
    wr_ctrl  = set_stb && (set_addr == A_CTRL);
    wr_hi    = set_stb && (set_addr == A_HI);
    wr_lo    = set_stb && (set_addr == A_LO);
    wr_cmd   = set_stb && (set_addr == A_CMD);
    wr_tmo   = set_stb && (set_addr == A_TMO);
    load_now = wr_cmd && set_data[0];
    arm_req  = wr_cmd && !set_data[0];
    wr_int   = '0;
    for (int k = 0; k < NUM_TICK; k++) begin
      wr_int[k] = set_stb && (set_addr == A_INT0 + 8'(k));
    end
  end

  // Edge detect on the synchronised PPS. The polarity comes from ctrl bit0.
  always_comb begin
    pps_ext = ctrl_rising ? (pps_s2 & ~pps_d) : (~pps_s2 & pps_d);
  end

  // A PPS load is only taken when an immediate load is not pending, so that
  // the staged value does not advance for a load that never happened.
  always_comb begin
    pps_load = pps_ext && (armed || sync_every) && !load_now;
    if (load_now || pps_load) begin
      time_next = staged;
    end else begin
      time_next = time_o + TIME_W'(1);
    end
  end

  // Staged value: auto-advance by one second after a PPS load (carry from lo
  // into hi only on this increment); a bus write overrides its own half.
  always_comb begin
    staged_sum     = pps_load ? (staged + TPS_INC) : staged;
    staged_lo_next = wr_lo ? set_data : staged_sum[31:0];
    staged_hi_next = wr_hi ? set_data[HI_W-1:0] : staged_sum[TIME_W-1:32];
  end

  // Two-flop synchroniser, edge flop and the registered pps_o pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pps_s1 <= 1'b0;
      pps_s2 <= 1'b0;
      pps_d  <= 1'b0;
      pps_o  <= 1'b0;
    end else begin
      pps_s1 <= pps_in;
      pps_s2 <= pps_s1;
      pps_d  <= pps_s2;
      pps_o  <= pps_ext;
    end
  end

  // Control registers and the armed flag. An arm request in the same cycle
  // as a PPS edge wins, so the arm applies to the following PPS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_rising <= 1'b0;
      sync_every  <= 1'b0;
      int_en      <= 1'b0;
      watch_en    <= 1'b0;
      armed       <= 1'b0;
      pps_timeout <= TIMEOUT_RST;
    end else begin
      if (wr_ctrl) begin
        ctrl_rising <= set_data[0];
        sync_every  <= set_data[1];
        int_en      <= set_data[2];
        watch_en    <= set_data[3];
      end
      if (wr_tmo) begin
        pps_timeout <= set_data;
      end
      if (arm_req) begin
        armed <= 1'b1;
      end else if (pps_ext) begin
        armed <= 1'b0;
      end
    end
  end

  // Master time, staged value, last-PPS capture and the epoch flag. The
  // epoch flag is computed from the next time so it lines up with time_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_o   <= '0;
      staged   <= '0;
      pps_time <= '0;
      epoch_o  <= 1'b0;
    end else begin
      time_o  <= time_next;
      staged  <= {staged_hi_next, staged_lo_next};
      epoch_o <= (time_next[27:0] == 28'd0);
      if (pps_ext) begin
        pps_time <= time_o;
      end
    end
  end

  // Tick channels: a tick fires whenever the count has reached the
  // interval, which also covers an interval lowered below the count.
  always_comb begin
    tick = '0;
    for (int k = 0; k < NUM_TICK; k++) begin
      tick[k] = (tick_cnt[k] >= interval[k]);
    end
  end

  assign tick_o = tick;

  // Interval writes also restart their channel's counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_TICK; k++) begin
        interval[k] <= INTERVAL_RST;
        tick_cnt[k] <= '0;
      end
      int_o <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_TICK; k++) begin
        if (wr_int[k]) begin
          interval[k] <= set_data;
          tick_cnt[k] <= '0;
        end else if (tick[k]) begin
          tick_cnt[k] <= '0;
        end else begin
          tick_cnt[k] <= tick_cnt[k] + 32'd1;
        end
      end
      int_o <= int_en & (|tick);
    end
  end

  // PPS-loss watchdog. The missing flag is sticky until the next PPS edge,
  // and dropping watch_en clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      since_pps     <= '0;
      pps_missing_o <= 1'b0;
    end else begin
      if (pps_ext) begin
        since_pps <= '0;
      end else if (since_pps != '1) begin
        since_pps <= since_pps + 32'd1;
      end
      if (!watch_en) begin
        pps_missing_o <= 1'b0;
      end else if (pps_ext) begin
        pps_missing_o <= 1'b0;
      end else if (since_pps > pps_timeout) begin
        pps_missing_o <= 1'b1;
      end
    end
  end

  // Readback. Reading address 0 freezes the full time in the snapshot so a
  // following read of address 1 returns the matching high word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_data  <= '0;
      snapshot <= '0;
    end else if (rb_stb) begin
      case (rb_addr)
        3'd0: begin
          snapshot <= time_o;
          rb_data  <= time_o[31:0];
        end
        3'd1:    rb_data <= 32'(snapshot >> 32);
        3'd2:    rb_data <= pps_time[31:0];
        3'd3:    rb_data <= 32'(pps_time >> 32);
        3'd4:    rb_data <= {29'd0, sync_every, armed, pps_missing_o};
        default: rb_data <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_time_sync_multi.sv
// tb_time_sync_multi
//   Directed and randomized bench for time_sync_multi. A behavioural model
//   of the time-keeper is advanced once per clock edge from the same inputs
//   and every output is compared after each edge.
module tb_time_sync_multi;

  localparam int TIME_W   = 64;
  localparam int NUM_TICK = 2;
  localparam int BASE     = 0;
  localparam int TPS      = 1000;
  localparam int DEF_INT  = 20;

  logic                clk      = 1'b0;
  logic                rst      = 1'b1;
  logic                set_stb  = 1'b0;
  logic [7:0]          set_addr = 8'd0;
  logic [31:0]         set_data = 32'd0;
  logic                rb_stb   = 1'b0;
  logic [2:0]          rb_addr  = 3'd0;
  logic                pps_in   = 1'b0;
  logic [31:0]         rb_data;
  logic [TIME_W-1:0]   time_o;
  logic                pps_o;
  logic [NUM_TICK-1:0] tick_o;
  logic                int_o;
  logic                epoch_o;
  logic                pps_missing_o;

  int   tests  = 0;
  int   failed = 0;
  logic pin    = 1'b0;
  int   t0, t1, ni;

  // Reference model state
  logic [63:0]     m_time, m_staged, m_pps_time, m_snap;
  logic            m_rising, m_sync, m_int_en, m_watch, m_armed, m_missing;
  logic            m_pps_o, m_int, m_epoch;
  logic [31:0]     m_timeout, m_since, m_rb;
  logic [31:0]     m_interval [NUM_TICK];
  longint unsigned m_age [NUM_TICK];
  bit              pin_hist[$];

  always #5 clk = ~clk;

  time_sync_multi #(
    .TIME_W(TIME_W), .NUM_TICK(NUM_TICK), .BASE(BASE),
    .TICKS_PER_SEC(TPS), .DEF_INTERVAL(DEF_INT)
  ) dut (
    .clk(clk), .rst(rst),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .rb_stb(rb_stb), .rb_addr(rb_addr), .rb_data(rb_data),
    .pps_in(pps_in), .time_o(time_o), .pps_o(pps_o), .tick_o(tick_o),
    .int_o(int_o), .epoch_o(epoch_o), .pps_missing_o(pps_missing_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // A channel ticks whenever the cycles since its last restart, taken
  // modulo (interval + 1), land on the interval itself.
  function automatic logic [NUM_TICK-1:0] tick_model();
    logic [NUM_TICK-1:0] t;
    for (int k = 0; k < NUM_TICK; k++) begin
      t[k] = (m_age[k] % (64'(m_interval[k]) + 64'd1)) == 64'(m_interval[k]);
    end
    return t;
  endfunction

  task automatic model_reset();
    m_time = '0; m_staged = '0; m_pps_time = '0; m_snap = '0;
    m_rising = 0; m_sync = 0; m_int_en = 0; m_watch = 0; m_armed = 0;
    m_missing = 0; m_pps_o = 0; m_int = 0; m_epoch = 0;
    m_timeout = 32'(TPS + TPS / 8); m_since = '0; m_rb = '0;
    for (int k = 0; k < NUM_TICK; k++) begin
      m_interval[k] = 32'(DEF_INT);
      m_age[k] = 0;
    end
    pin_hist.delete();
    for (int i = 0; i < 4; i++) pin_hist.push_back(1'b0);
  endtask

  // Advance the model by one clock edge using the inputs held before it.
  // The pin sampled two and three edges ago decides the edge seen now.
  task automatic model_edge();
    logic ext, ld_now, arm, pl;
    logic [NUM_TICK-1:0] tk;
    logic [63:0] nt, st;
    int n;
    pin_hist.push_back(pps_in);
    n = pin_hist.size();
    ext = m_rising ? (pin_hist[n-3] & ~pin_hist[n-4]) : (~pin_hist[n-3] & pin_hist[n-4]);
    if (n > 16) void'(pin_hist.pop_front());
    tk     = tick_model();
    ld_now = set_stb && (set_addr == 8'(BASE + 3)) && set_data[0];
    arm    = set_stb && (set_addr == 8'(BASE + 3)) && !set_data[0];
    pl     = ext && (m_armed || m_sync) && !ld_now;
    nt     = (ld_now || pl) ? m_staged : m_time + 64'd1;
    st     = pl ? m_staged + 64'(TPS) : m_staged;
    if (set_stb && set_addr == 8'(BASE + 2)) st[31:0]  = set_data;
    if (set_stb && set_addr == 8'(BASE + 1)) st[63:32] = set_data;
    if (rb_stb) begin
      case (rb_addr)
        3'd0: begin m_rb = m_time[31:0]; m_snap = m_time; end
        3'd1: m_rb = m_snap[63:32];
        3'd2: m_rb = m_pps_time[31:0];
        3'd3: m_rb = m_pps_time[63:32];
        3'd4: m_rb = {29'd0, m_sync, m_armed, m_missing};
        default: m_rb = '0;
      endcase
    end
    if (ext) m_pps_time = m_time;
    m_missing = !m_watch ? 1'b0 : ext ? 1'b0 : (m_since > m_timeout) ? 1'b1 : m_missing;
    m_since   = ext ? 32'd0 : (m_since == 32'hFFFF_FFFF) ? m_since : m_since + 32'd1;
    m_armed   = arm ? 1'b1 : ext ? 1'b0 : m_armed;
    m_int     = m_int_en & (|tk);
    for (int k = 0; k < NUM_TICK; k++) begin
      if (set_stb && set_addr == 8'(BASE + 8 + k)) begin
        m_interval[k] = set_data;
        m_age[k] = 0;
      end else begin
        m_age[k]++;
      end
    end
    if (set_stb && set_addr == 8'(BASE)) begin
      m_rising = set_data[0]; m_sync = set_data[1];
      m_int_en = set_data[2]; m_watch = set_data[3];
    end
    if (set_stb && set_addr == 8'(BASE + 4)) m_timeout = set_data;
    m_time   = nt;
    m_staged = st;
    m_epoch  = (nt[27:0] == 28'd0);
    m_pps_o  = ext;
  endtask

  task automatic checkOutput();
    chk("time_o", 64'(time_o), m_time);
    chk("pps_o", 64'(pps_o), 64'(m_pps_o));
    chk("tick_o", 64'(tick_o), 64'(tick_model()));
    chk("int_o", 64'(int_o), 64'(m_int));
    chk("epoch_o", 64'(epoch_o), 64'(m_epoch));
    chk("pps_missing_o", 64'(pps_missing_o), 64'(m_missing));
    chk("rb_data", 64'(rb_data), 64'(m_rb));
  endtask

  task automatic applyStimulus(input logic stb, input logic [7:0] addr, input logic [31:0] data,
                               input logic rbs, input logic [2:0] rba);
    set_stb = stb; set_addr = addr; set_data = data;
    rb_stb = rbs; rb_addr = rba; pps_in = pin;
    @(posedge clk);
    model_edge();
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'd0, 32'd0, 1'b0, 3'd0);
  endtask

  task automatic writeReg(input int off, input logic [31:0] data);
    applyStimulus(1'b1, 8'(BASE + off), data, 1'b0, 3'd0);
  endtask

  task automatic readReg(input logic [2:0] a);
    applyStimulus(1'b0, 8'd0, 32'd0, 1'b1, a);
  endtask

  task automatic ppsPulse();
    pin = 1'b1; idle(3);
    pin = 1'b0; idle(4);
  endtask

  // Reset is raised half-way between clock edges so it acts asynchronously.
  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; pin = 1'b0; pps_in = 1'b0;
    set_stb = 1'b0; set_addr = '0; set_data = '0; rb_stb = 1'b0; rb_addr = '0;
    model_reset();
    #1;
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    doReset();
    chk("reset_time", 64'(time_o), 64'd0);
    chk("reset_rb", 64'(rb_data), 64'd0);
    idle(3);

    // Immediate load of a value above 32 bits
    writeReg(1, 32'd1);
    writeReg(2, 32'd0);
    writeReg(3, 32'd1);
    chk("load_now_time", 64'(time_o), 64'h1_0000_0000);
    chk("load_now_epoch", 64'(epoch_o), 64'd1);
    idle(1);
    chk("load_now_incr", 64'(time_o), 64'h1_0000_0001);

    // Armed load on a rising PPS edge
    writeReg(0, 32'd1);
    writeReg(1, 32'd0);
    writeReg(2, 32'd500);
    writeReg(3, 32'd0);
    readReg(3'd4);
    chk("armed_set", 64'(rb_data), 64'd2);
    pin = 1'b1;
    idle(2);
    chk("pps_early", 64'(pps_o), 64'd0);
    idle(1);
    chk("pps_latency", 64'(pps_o), 64'd1);
    chk("pps_load", 64'(time_o), 64'd500);
    pin = 1'b0;
    idle(4);
    readReg(3'd4);
    chk("armed_clear", 64'(rb_data), 64'd0);
    writeReg(3, 32'd0);
    pin = 1'b1; idle(3);
    chk("staged_next_sec", 64'(time_o), 64'd1500);
    pin = 1'b0; idle(4);

    // Reload on every PPS, one second apart
    writeReg(0, 32'd3);
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 1000; c++) begin
        pin = (c < 4);
        idle(1);
        if (c == 1 && p > 0) chk("sync_continuous", 64'(time_o), 64'(2499 + 1000 * p));
        if (c == 2) chk("sync_reload", 64'(time_o), 64'(2500 + 1000 * p));
      end
    end
    pin = 1'b0;

    // Tick channels and interrupt
    writeReg(0, 32'd5);
    writeReg(8, 32'd3);
    writeReg(9, 32'd0);
    t0 = 0; t1 = 0; ni = 0;
    for (int i = 0; i < 12; i++) begin
      idle(1);
      t0 += int'(tick_o[0]);
      t1 += int'(tick_o[1]);
      ni += int'(int_o);
    end
    chk("tick0_count", 64'(t0), 64'd3);
    chk("tick1_count", 64'(t1), 64'd12);
    chk("int_count", 64'(ni), 64'd12);

    // PPS-loss watchdog
    writeReg(4, 32'd50);
    writeReg(0, 32'd9);
    ppsPulse();
    idle(45);
    chk("watch_quiet", 64'(pps_missing_o), 64'd0);
    idle(15);
    chk("watch_missing", 64'(pps_missing_o), 64'd1);
    readReg(3'd4);
    chk("status_missing", 64'(rb_data), 64'd1);
    pin = 1'b1; idle(2);
    chk("missing_held", 64'(pps_missing_o), 64'd1);
    idle(1);
    chk("missing_clear_pps", 64'(pps_missing_o), 64'd0);
    pin = 1'b0; idle(4);
    idle(60);
    chk("watch_missing2", 64'(pps_missing_o), 64'd1);
    writeReg(0, 32'd1);
    idle(1);
    chk("missing_clear_en", 64'(pps_missing_o), 64'd0);

    // Snapshot readback across a low-word wrap
    writeReg(1, 32'd5);
    writeReg(2, 32'hFFFF_FFF0);
    writeReg(3, 32'd1);
    idle(14);
    readReg(3'd0);
    chk("snap_lo", 64'(rb_data), 64'hFFFF_FFFE);
    readReg(3'd1);
    chk("snap_hi", 64'(rb_data), 64'd5);
    chk("wrap_time", 64'(time_o), 64'h6_0000_0000);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      logic        stb, rbs;
      logic [7:0]  addr;
      logic [31:0] data;
      stb  = ($urandom_range(0, 9) < 3);
      addr = 8'(BASE);
      data = '0;
      case ($urandom_range(0, 6))
        0: begin addr = 8'(BASE);     data = 32'($urandom_range(0, 15)); end
        1: begin addr = 8'(BASE + 1); data = $urandom; end
        2: begin addr = 8'(BASE + 2); data = $urandom; end
        3: begin addr = 8'(BASE + 3); data = 32'($urandom_range(0, 1)); end
        4: begin addr = 8'(BASE + 4); data = 32'($urandom_range(20, 200)); end
        5: begin addr = 8'(BASE + 8); data = 32'($urandom_range(0, 7)); end
        default: begin addr = 8'(BASE + 9); data = 32'($urandom_range(0, 7)); end
      endcase
      rbs = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 24) == 0) pin = ~pin;
      applyStimulus(stb, addr, data, rbs, 3'($urandom_range(0, 7)));
    end

    // Reset in the middle of operation drops a pending armed load
    pin = 1'b0;
    idle(4);
    writeReg(0, 32'd1);
    writeReg(3, 32'd0);
    doReset();
    readReg(3'd4);
    chk("armed_lost", 64'(rb_data), 64'd0);
    ppsPulse();
    chk("armed_lost_time", 64'(time_o), 64'd8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
